// File: rtl/rect_plot_engine.sv
// rect_plot_engine
//   Command-driven rectangle painter for the VGA drawing path. Producers push
//   rectangle commands into a small FIFO; the engine walks each one in raster
//   order and emits one pixel per cycle under valid/ready flow control.
//   Modes: 0 fill, 1 outline, 2 dashed rows, 3 treated as fill.
//
// Ports
//   clk, resetn          clock; asynchronous active-high reset
//   cmd_valid/cmd_ready  command handshake (cmd_ready = FIFO not full)
//   cmd_x, cmd_y         rectangle origin
//   cmd_w, cmd_h         rectangle size in pixels (0 in either => no pixels)
//   cmd_color, cmd_mode  pixel colour and drawing mode
//   plot/plot_ready      pixel handshake towards the VGA adapter
//   x, y, color, qout    current pixel; qout = {x, y}
//   busy                 FIFO non-empty or engine active
//   done                 one-cycle pulse per completed command
module rect_plot_engine #(
    parameter int XW       = 8,
    parameter int YW       = 7,
    parameter int CW       = 3,
    parameter int DW       = 8,
    parameter int DEPTH    = 4,
    parameter int DASH_ON  = 3,
    parameter int DASH_OFF = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [XW-1:0]    cmd_x,
    input  logic [YW-1:0]    cmd_y,
    input  logic [DW-1:0]    cmd_w,
    input  logic [DW-1:0]    cmd_h,
    input  logic [CW-1:0]    cmd_color,
    input  logic [1:0]       cmd_mode,
    output logic             plot,
    input  logic             plot_ready,
    output logic [XW-1:0]    x,
    output logic [YW-1:0]    y,
    output logic [CW-1:0]    color,
    output logic [XW+YW-1:0] qout,
    output logic             busy,
    output logic             done
);

    localparam int AW  = $clog2(DEPTH);
    localparam int PER = DASH_ON + DASH_OFF;
    localparam int PHW = (PER > 1) ? $clog2(PER) : 1;

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [DW-1:0] w;
        logic [DW-1:0] h;
        logic [CW-1:0] color;
        logic [1:0]    mode;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Command FIFO: pointers carry one extra wrap bit to tell full from empty.
    cmd_t          mem [DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          full, empty, push, pop;
    cmd_t          head;

    state_t        state;
    logic [XW-1:0] wx;
    logic [YW-1:0] wy;
    logic [DW-1:0] ww, wh, cx, cy;
    logic [1:0]    wmode;
    logic [CW-1:0] wcol;
    logic [PHW-1:0] ph;

    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty     = (wr_ptr == rd_ptr);
    assign cmd_ready = !full && !resetn;
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state == IDLE) && !empty;
    assign head      = mem[rd_ptr[AW-1:0]];
    assign qout      = {x, y};
    assign busy      = (state != IDLE) || !empty;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, cmd_mode};
        end
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Next emitted pixel after (cx, cy). Skipped pixels (outline interior,
    // dash gaps) are jumped over directly so no cycle is wasted on them.
    logic [DW-1:0]  last_col, last_row, nx_cx, nx_cy;
    logic [DW:0]    step_cx;
    logic [PHW-1:0] nph, nx_ph;
    logic           edge_row, wrap, last_pix;

    assign last_col = ww - DW'(1);
    assign last_row = wh - DW'(1);
    assign edge_row = (cy == '0) || (cy == last_row);

    always_comb begin
        step_cx = {1'b0, cx} + (DW+1)'(1);
        nph     = ph + PHW'(1);
        if (wmode == 2'd1 && !edge_row) begin
            step_cx = {1'b0, last_col};
        end else if (wmode == 2'd2 && ph == PHW'(DASH_ON - 1)) begin
            // End of the lit run: hop over the dark run to the next dash.
            step_cx = {1'b0, cx} + (DW+1)'(DASH_OFF + 1);
            nph     = '0;
        end
        // A step past the last column (partial dash period) also ends the row.
        wrap     = (cx == last_col) || (step_cx > {1'b0, last_col});
        last_pix = wrap && (cy == last_row);
        if (wrap) begin
            nx_cx = '0;
            nx_cy = cy + DW'(1);
            nx_ph = '0;
        end else begin
            nx_cx = step_cx[DW-1:0];
            nx_cy = cy;
            nx_ph = nph;
        end
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state <= IDLE;
            plot  <= 1'b0;
            done  <= 1'b0;
            x     <= '0;
            y     <= '0;
            color <= '0;
            wx    <= '0;
            wy    <= '0;
            ww    <= '0;
            wh    <= '0;
            wcol  <= '0;
            wmode <= '0;
            cx    <= '0;
            cy    <= '0;
            ph    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        wx    <= head.x;
                        wy    <= head.y;
                        ww    <= head.w;
                        wh    <= head.h;
                        wcol  <= head.color;
                        wmode <= head.mode;
                        cx    <= '0;
                        cy    <= '0;
                        ph    <= '0;
                        if (head.w == '0 || head.h == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            // (0,0) is emitted in every mode.
                            state <= RUN;
                            plot  <= 1'b1;
                            x     <= head.x;
                            y     <= head.y;
                            color <= head.color;
                        end
                    end
                end
                RUN: begin
                    if (plot_ready) begin
                        if (last_pix) begin
                            state <= DONE;
                            plot  <= 1'b0;
                            color <= '0;
                            done  <= 1'b1;
                        end else begin
                            cx <= nx_cx;
                            cy <= nx_cy;
                            ph <= nx_ph;
                            x  <= wx + XW'(nx_cx);
                            y  <= wy + YW'(nx_cy);
                        end
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/rect_plot_engine.md
Name: rect_plot_engine

Overview:
Parametrised pixel-sequencing engine for the VGA drawing path. It generalises the hard-coded dash, gallows, body-part and clear-screen painters into one command-driven block. Producers push rectangle commands into an internal FIFO. The engine walks each command in raster order and emits one pixel per cycle under valid/ready flow control. It supports fill, outline and dashed-row modes. It sits between the game datapath (command source) and the VGA adapter (pixel sink).

Parameters:
XW, 8, x coordinate width (160-column screen)
YW, 7, y coordinate width (120-row screen)
CW, 3, colour width
DW, 8, width/height field width
DEPTH, 4, command FIFO depth (power of 2, >=2)
DASH_ON, 3, lit pixels per dash period (mode 2)
DASH_OFF, 2, dark pixels per dash period (mode 2)

Ports:
clk  in  1  system clock
resetn  in  1  reset, asynchronous, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  FIFO can accept
cmd_x  in  XW  origin x
cmd_y  in  YW  origin y
cmd_w  in  DW  width in pixels
cmd_h  in  DW  height in pixels
cmd_color  in  CW  pixel colour
cmd_mode  in  2  0 fill, 1 outline, 2 dashed rows, 3 reserved (treated as fill)
plot  out  1  pixel valid
plot_ready  in  1  sink accepts pixel
x  out  XW  pixel x
y  out  YW  pixel y
color  out  CW  pixel colour
qout  out  XW+YW  {x, y} packed for the VGA adapter
busy  out  1  FIFO non-empty or engine not IDLE
done  out  1  one-cycle pulse per completed command

Behaviour:
- Reset (async, resetn=1): FIFO emptied; FSM to IDLE; plot, x, y, color, qout, busy, done = 0; cmd_ready = 0 while reset is held, and = !full after release.
- Push: on edge with cmd_valid & cmd_ready, the command is written to the FIFO. Pushes while full are impossible because cmd_ready=0. Simultaneous push/pop is allowed at any occupancy.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If FIFO is non-empty, pop into working registers and zero cx, cy.
  - If w==0 or h==0, go to DONE; otherwise go to RUN with plot=1 and the first pixel driven.
  - Latency: a command pushed at edge A into an empty FIFO with the engine IDLE gives plot=1 after edge A+1.
- RUN:
  - Outputs are registered and held stable while plot & !plot_ready.
  - On plot & plot_ready, advance to the next emitted pixel in the next cycle. Throughput is 1 pixel/cycle when plot_ready is held high.
  - Raster order: cx 0..w-1 inner, cy 0..h-1 outer.
  - After the last pixel handshakes, go to DONE with plot=0.
- Mode 0 (fill): every (cx, cy) is emitted; w*h pixels.
- Mode 1 (outline): only pixels with cy==0, cy==h-1, cx==0 or cx==w-1 are emitted.
  - On interior rows, cx jumps 0 -> w-1 directly; no dead cycles.
  - w==1 or h==1 degenerates to a line with no duplicates.
  - 2*w + 2*h - 4 pixels when w,h >= 2.
- Mode 2 (dashed): pixels where (cx mod (DASH_ON+DASH_OFF)) < DASH_ON are emitted.
  - Dark pixels are skipped without consuming cycles.
  - A row whose final period is partial emits only its lit prefix.
- Coordinates: x = (x0 + cx) truncated to XW; y = (y0 + cy) truncated to YW. Overflow wraps modulo 2^XW and 2^YW, with no clipping.
- qout is always {x, y}; color is the working colour while plot=1, else 0.
- DONE: done=1 for exactly one cycle, then return to IDLE. The next command's first pixel appears 2 cycles after the previous last handshake.
- busy = (state != IDLE) | !empty.
- Reset mid-command: outputs clear immediately, no done pulse is issued, and pending commands are discarded.

Test Plan:
- Fill (mode 0), x=10, y=20, w=3, h=2, color=5, plot_ready=1 -> 6 consecutive plots (10,20),(11,20),(12,20),(10,21),(11,21),(12,21), each color=5; done pulses once, the cycle after the last plot; busy then falls.
- Outline (mode 1), x=10, y=20, w=4, h=3 -> 10 plots in the order (10..13,20),(10,21),(13,21),(10..13,22); (11,21) and (12,21) never appear; no idle cycles between plots.
- Dashed (mode 2), x=30, y=78, w=12, h=1 with DASH_ON=3, DASH_OFF=2 -> x = 30,31,32,35,36,37,40,41 at y=78; 8 plots then done.
- Backpressure: fill 3x2 with plot_ready = 1,0,0,1,0,1,... -> x/y/color held constant during stalls; exactly 6 accepted pixels, none duplicated or dropped.
- FIFO full, DEPTH=4: hold plot_ready=0 and push 6 commands back to back -> 1 in working regs plus 4 in FIFO are accepted; cmd_ready=0 on the 6th; releasing plot_ready drains all 5 with 5 done pulses.
- Edge cases:
  - x=250, w=10 fill -> x wraps as 250..255, 0..3.
  - w=0 command -> done pulse with no plot.
  - resetn asserted mid-fill -> plot=0, qout=0 immediately; no done; busy=0.
